// File: rtl/jtkicker_gfxarb_if.sv
// Bus bundle for the graphics arbiter: two cached requesters plus the shared SDRAM port.
// The arbiter takes the slave view; the video pipeline and SDRAM controller take the master view.
`timescale 1ns/1ps
interface jtkicker_gfxarb_if #(
  parameter int SCR_AW = 13,
  parameter int OBJ_AW = 14,
  parameter int RAW    = 15
);
  logic              scr_cs;
  logic [SCR_AW-1:0] scr_addr;
  logic [31:0]       scr_data;
  logic              scr_ok;
  logic              obj_cs;
  logic [OBJ_AW-1:0] obj_addr;
  logic [31:0]       obj_data;
  logic              obj_ok;
  logic              rom_cs;
  logic [RAW-1:0]    rom_addr;
  logic [31:0]       rom_data;
  logic              rom_ok;

  modport slave (
    input  scr_cs, scr_addr, obj_cs, obj_addr, rom_data, rom_ok,
    output scr_data, scr_ok, obj_data, obj_ok, rom_cs, rom_addr
  );

  modport master (
    output scr_cs, scr_addr, obj_cs, obj_addr, rom_data, rom_ok,
    input  scr_data, scr_ok, obj_data, obj_ok, rom_cs, rom_addr
  );
endinterface

// File: rtl/jtkicker_gfxarb.sv
// Shares one SDRAM graphics port between the scroll and object fetchers, with a one-word
// tag/data cache per requester, round-robin miss arbitration and timeout-driven retry.
`timescale 1ns/1ps
module jtkicker_gfxarb #(
  parameter int             SCR_AW   = 13,
  parameter int             OBJ_AW   = 14,
  parameter int             RAW      = 15,
  parameter logic [RAW-1:0] OBJ_BASE = 15'h2000,
  parameter logic [7:0]     TMO      = 8'd255
) (
  input  logic               clk,
  input  logic               rst,
  jtkicker_gfxarb_if.slave   bus
);

  localparam int TAG_W = (OBJ_AW > SCR_AW) ? OBJ_AW : SCR_AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RETRY = 2'd3
  } state_t;

  state_t            state_r, state_nxt_s;
  logic              last_obj_r;
  logic              req_obj_r;
  logic [TAG_W-1:0]  req_tag_r;
  logic              rom_cs_r;
  logic [RAW-1:0]    rom_addr_r;
  logic [31:0]       scr_data_r, obj_data_r;
  logic [SCR_AW-1:0] scr_tag_r;
  logic [OBJ_AW-1:0] obj_tag_r;
  logic              scr_valid_r, obj_valid_r;
  logic [7:0]        cnt_r, cnt_inc_s;
  logic              scr_hit_s, obj_hit_s, scr_miss_s, obj_miss_s;
  logic              grant_scr_s, grant_obj_s, fill_s, timeout_s;

  assign scr_hit_s  = bus.scr_cs & scr_valid_r & (scr_tag_r == bus.scr_addr);
  assign obj_hit_s  = bus.obj_cs & obj_valid_r & (obj_tag_r == bus.obj_addr);
  assign scr_miss_s = bus.scr_cs & ~scr_hit_s;
  assign obj_miss_s = bus.obj_cs & ~obj_hit_s;
  assign cnt_inc_s  = cnt_r + 8'd1;

  assign bus.scr_ok   = scr_hit_s;
  assign bus.obj_ok   = obj_hit_s;
  assign bus.scr_data = scr_data_r;
  assign bus.obj_data = obj_data_r;
  assign bus.rom_cs   = rom_cs_r;
  assign bus.rom_addr = rom_addr_r;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and per-cycle control strobes
  always_comb begin
    state_nxt_s = state_r;
    grant_scr_s = 1'b0;
    grant_obj_s = 1'b0;
    fill_s      = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // On a double miss the requester not served last time wins
        if (scr_miss_s && obj_miss_s) begin
          if (last_obj_r) begin
            grant_scr_s = 1'b1;
          end else begin
            grant_obj_s = 1'b1;
          end
        end else if (scr_miss_s) begin
          grant_scr_s = 1'b1;
        end else if (obj_miss_s) begin
          grant_obj_s = 1'b1;
        end else begin
          grant_scr_s = 1'b0;
        end
        if (grant_scr_s || grant_obj_s) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: state_nxt_s = WAIT;
      WAIT: begin
        if (bus.rom_ok) begin
          fill_s      = 1'b1;
          state_nxt_s = IDLE;
        end else if (cnt_inc_s == TMO) begin
          timeout_s   = 1'b1;
          state_nxt_s = RETRY;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RETRY:   state_nxt_s = ISSUE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Request latch, ROM port outputs, cache fill and timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_obj_r  <= 1'b1;
      req_obj_r   <= 1'b0;
      req_tag_r   <= '0;
      rom_cs_r    <= 1'b0;
      rom_addr_r  <= '0;
      scr_data_r  <= 32'd0;
      obj_data_r  <= 32'd0;
      scr_tag_r   <= '0;
      obj_tag_r   <= '0;
      scr_valid_r <= 1'b0;
      obj_valid_r <= 1'b0;
      cnt_r       <= 8'd0;
    end else begin
      if (grant_scr_s) begin
        req_obj_r  <= 1'b0;
        req_tag_r  <= TAG_W'(bus.scr_addr);
        rom_addr_r <= RAW'(bus.scr_addr);
        rom_cs_r   <= 1'b1;
        last_obj_r <= 1'b0;
      end else if (grant_obj_s) begin
        req_obj_r  <= 1'b1;
        req_tag_r  <= TAG_W'(bus.obj_addr);
        rom_addr_r <= RAW'(bus.obj_addr) + OBJ_BASE;
        rom_cs_r   <= 1'b1;
        last_obj_r <= 1'b1;
      end else if (fill_s) begin
        rom_cs_r <= 1'b0;
        if (req_obj_r) begin
          obj_data_r  <= bus.rom_data;
          obj_tag_r   <= req_tag_r[OBJ_AW-1:0];
          obj_valid_r <= 1'b1;
        end else begin
          scr_data_r  <= bus.rom_data;
          scr_tag_r   <= req_tag_r[SCR_AW-1:0];
          scr_valid_r <= 1'b1;
        end
      end else if (timeout_s) begin
        rom_cs_r <= 1'b0;
      end else if (state_r == RETRY) begin
        rom_cs_r <= 1'b1;
      end else begin
        rom_cs_r <= rom_cs_r;
      end

      if (state_r == ISSUE) begin
        cnt_r <= 8'd0;
      end else if (state_r == WAIT && !bus.rom_ok) begin
        cnt_r <= cnt_inc_s;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule
